// File: rtl/procesor_pkg.sv
// procesor_pkg: shared instruction classes, sub-codes, ALU ops, flag indices and FSM states for procesor_mc
package procesor_pkg;
  localparam logic [1:0] CL_REG = 2'd0;
  localparam logic [1:0] CL_IMM = 2'd1;
  localparam logic [1:0] CL_MEM = 2'd2;
  localparam logic [1:0] CL_CTL = 2'd3;
  localparam logic [3:0] C_NOP  = 4'd0;
  localparam logic [3:0] C_STR  = 4'd1;
  localparam logic [3:0] C_STM  = 4'd2;
  localparam logic [3:0] C_JMP  = 4'd3;
  localparam logic [3:0] C_JZ   = 4'd4;
  localparam logic [3:0] C_JC   = 4'd5;
  localparam logic [3:0] C_CALL = 4'd6;
  localparam logic [3:0] C_RET  = 4'd7;
  localparam logic [3:0] C_HALT = 4'd15;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LD  = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;
  localparam int F_Z = 0;
  localparam int F_C = 1;
  localparam int F_N = 2;
  localparam int F_V = 3;
  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
endpackage

// File: rtl/procesor_mc_regfile.sv
// regfile_p: 2**REG_AW x DATA_W register file; ports clk/rst, sync write (we/waddr/wdata), comb read (raddr/rdata)
module regfile_p #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] rf [2**REG_AW];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 2**REG_AW; i++) rf[i] <= '0;
    else if (we) rf[waddr] <= wdata;
  assign rdata = rf[raddr];
endmodule

// File: rtl/procesor_mc.sv
// procesor_mc: multi-cycle accumulator core; ports clk/rst, ins_addr/ins_data ROM, mem_* req/ack data bus, halted, dbg_a
module procesor_mc
  import procesor_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W = 16,
  parameter int REG_AW = 5,
  parameter int MEM_AW = 10,
  localparam int INS_W = DATA_W + 6
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   ins_addr,
  input  logic [INS_W-1:0]  ins_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [DATA_W-1:0] dbg_a
);
  state_t state, state_n;
  logic [PC_W-1:0] pc, pc_n, pc_inc, link;
  logic [DATA_W-1:0] a, b, res, rf_rdata, op;
  logic [DATA_W:0] sum, dif;
  logic [3:0] flags, flags_n, sub;
  logic [INS_W-1:0] ir;
  logic [1:0] cls;
  logic ctl, is_mem_op, is_halt, jump, alu_we, c, v;
  assign cls = ir[INS_W-1 -: 2];
  assign sub = ir[INS_W-3 -: 4];
  assign op = ir[DATA_W-1:0];
  assign ctl = cls == CL_CTL;
  assign is_mem_op = cls == CL_MEM || (ctl && sub == C_STM);
  assign is_halt = ctl && sub == C_HALT;
  assign pc_inc = pc + 1'b1;
  assign b = cls == CL_REG ? rf_rdata : cls == CL_IMM ? op : mem_rdata;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign alu_we = (state == EXEC && !cls[1]) || (state == MEM && mem_ack && cls == CL_MEM);
  assign jump = ctl && (sub == C_JMP || sub == C_CALL || (sub == C_JZ && flags[F_Z]) || (sub == C_JC && flags[F_C]));
  assign mem_req = state == MEM;
  assign mem_we = mem_req && ctl;
  assign halted = state == HALT;
  assign ins_addr = pc;
  assign dbg_a = a;
  regfile_p #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clk(clk),
    .rst(rst),
    .we(state == EXEC && ctl && sub == C_STR),
    .waddr(op[REG_AW-1:0]),
    .wdata(a),
    .raddr(op[REG_AW-1:0]),
    .rdata(rf_rdata)
  );
  always_comb begin
    res = '0;
    c = 1'b0;
    v = flags[F_V];
    case (sub[2:0])
      OP_ADD: begin
        res = sum[DATA_W-1:0];
        c = sum[DATA_W];
        v = a[DATA_W-1] == b[DATA_W-1] && res[DATA_W-1] != a[DATA_W-1];
      end
      OP_SUB: begin
        res = dif[DATA_W-1:0];
        c = dif[DATA_W];
        v = a[DATA_W-1] != b[DATA_W-1] && res[DATA_W-1] != a[DATA_W-1];
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_LD:  res = b;
      OP_SHL: begin
        res = a << 1;
        c = a[DATA_W-1];
      end
      default: begin
        res = a >> 1;
        c = a[0];
      end
    endcase
    flags_n = {v, res[DATA_W-1], c, res == '0};
  end
  always_comb begin
    state_n = state;
    pc_n = pc;
    case (state)
      FETCH: state_n = EXEC;
      EXEC: begin
        state_n = is_mem_op ? MEM : is_halt ? HALT : FETCH;
        pc_n = is_mem_op || is_halt ? pc : jump ? op[PC_W-1:0] : ctl && sub == C_RET ? link : pc_inc;
      end
      MEM: begin
        state_n = mem_ack ? FETCH : MEM;
        pc_n = mem_ack ? pc_inc : pc;
      end
      default: state_n = HALT;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FETCH;
      pc <= '0;
      a <= '0;
      flags <= '0;
      link <= '0;
      ir <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      a <= alu_we ? res : a;
      flags <= alu_we ? flags_n : flags;
      if (state == FETCH) ir <= ins_data;
      if (state == EXEC && ctl && sub == C_CALL) link <= pc_inc;
      if (state == EXEC && is_mem_op) begin
        mem_addr <= op[MEM_AW-1:0];
        mem_wdata <= a;
      end
    end
endmodule

// File: doc/procesor_mc.md
Name: procesor_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle core: FETCH/EXEC/MEM/HALT state machine.
- Generic data, PC, register-file and memory address widths.
- Data memory sits behind a req/ack handshake with arbitrary wait states. Adds a CALL/RET link register, conditional jumps on flags, and a HALT state.
- Top-level core; the instruction ROM and data memory are external.

Parameters:
DATA_W, 16, accumulator/register/memory word width and operand field width
PC_W, 16, program counter width (PC_W <= DATA_W)
REG_AW, 5, register file address width, 2**REG_AW registers
MEM_AW, 10, data memory address width (MEM_AW <= DATA_W)
INS_W, DATA_W+6, instruction width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
ins_addr  out  PC_W  instruction address, equals PC
ins_data  in  INS_W  instruction word, combinational from ROM
mem_req  out  1  data memory request
mem_we  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  MEM_AW  data memory address
mem_wdata  out  DATA_W  write data (A)
mem_rdata  in  DATA_W  read data, valid when mem_ack=1
mem_ack  in  1  transfer complete
halted  out  1  core in HALT
dbg_a  out  DATA_W  accumulator A

Behaviour:
- Reset (async, immediate): state=FETCH, PC=0, A=0, flags=0, link=0, all registers=0, IR=0.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
  - A reset during MEM drops mem_req at once; a late ack is ignored.
- Encoding: IR[INS_W-1:INS_W-2]=class, IR[INS_W-3:INS_W-6]=sub, IR[DATA_W-1:0]=operand.
- Classes:
  - 00 ALU-reg: A<=ALU(sub[2:0], A, R[operand[REG_AW-1:0]]).
  - 01 ALU-imm: A<=ALU(sub[2:0], A, operand).
  - 10 ALU-mem: A<=ALU(sub[2:0], A, mem[operand[MEM_AW-1:0]]).
  - In all ALU classes, sub[3] is reserved and ignored.
  - 11 control: sub=0 NOP, 1 STR R[operand]<=A, 2 STM mem[operand]<=A, 3 JMP, 4 JZ, 5 JC, 6 CALL, 7 RET, 15 HALT; all other codes act as NOP.
- ALU ops: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 LOAD (res=B), 6 SHL by 1, 7 SHR logical by 1.
- Flags [3:0] = {V,N,C,Z}, updated by every ALU instruction:
  - Z = (res==0); N = res[DATA_W-1].
  - C: carry-out for ADD; borrow for SUB (A<B unsigned); the shifted-out bit for SHL/SHR; 0 otherwise.
  - V: signed overflow for ADD/SUB; unchanged otherwise.
  - Control instructions leave flags unchanged.
- FSM:
  - FETCH (1 cycle): IR<=ins_data; go to EXEC.
  - EXEC:
    - Class 00/01: write A and flags, PC<=PC+1, go to FETCH.
    - Class 10 or STM: go to MEM; PC unchanged.
    - JMP: PC<=operand[PC_W-1:0].
    - JZ/JC: jump if Z/C is set, else PC+1.
    - CALL: link<=PC+1 and PC<=operand.
    - RET: PC<=link.
    - HALT: go to HALT; PC unchanged.
    - Every other case goes back to FETCH.
  - MEM: mem_req=1 with mem_addr/mem_we/mem_wdata stable. On the cycle mem_ack=1:
    - Read: ALU result written to A and flags.
    - Write: nothing internal changes.
    - Then PC<=PC+1, go to FETCH, and mem_req drops in the next cycle.
    - No timeout; the core waits indefinitely.
  - HALT: terminal; halted=1; exits only on rst.
- Latency: 2 cycles for non-memory instructions; 2 + (cycles in MEM, minimum 1) for memory instructions.
- PC+1 wraps modulo 2**PC_W; link holds a single level (a nested CALL overwrites it).
- mem_ack outside MEM is ignored. mem_addr and mem_wdata are registered; both hold their last value while idle.
- Register addresses wider than 2**REG_AW are truncated to REG_AW bits.

Decomposition:
- Package procesor_pkg:
  - class codes, control sub-codes, ALU op codes;
  - flag bit indices;
  - the FSM state enum {FETCH, EXEC, MEM, HALT}.
- Sub-module regfile_p (parametrised by DATA_W, REG_AW): one synchronous write port, one combinational read port, async reset to 0.
- ALU, link, PC and FSM stay inline in procesor_mc.

Test Plan:
- ALU-imm LOAD 0x7FFF, ADD imm 1 (DATA_W=16) -> A=0x8000, N=1, V=1, C=0, Z=0; each instruction takes 2 cycles.
- STR R3 then ALU-reg SUB R3 -> A=0, Z=1, C=0; JZ 0x0010 -> ins_addr=0x0010; JC with C=0 -> PC+1.
- ALU-mem LOAD @0x005, memory acks after 3 wait cycles returning 0x1234 -> mem_req high for exactly 4 cycles, A=0x1234, then FETCH.
- STM @0x3FF with A=0xBEEF, ack on the first MEM cycle -> one cycle with mem_req=1, mem_we=1, mem_addr=0x3FF, mem_wdata=0xBEEF.
- CALL 0x0040 at PC=0x0005, then RET at 0x0040 -> link=0x0006, PC returns to 0x0006; JMP at PC=0xFFFF to 0xFFFF, then NOP at 0xFFFF -> PC wraps to 0x0000.
- rst asserted mid-MEM (mem_req=1) -> mem_req=0 in the same cycle and all state returns to reset values. HALT -> halted=1, ins_addr frozen for 20+ cycles; rst clears halted.
